binary_to_bcd: RTL

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that turns an unsigned binary value, such as the game score or timer, into packed BCD digits. The packed BCD digits feed the per-digit seven-segment decoders. It sits between game logic and the display path. It registers its result so the display sees a stable value between conversions.

---
 rtl/display_pkg.sv | 16 +
 rtl/bcd_digit_adjust.sv | 25 ++
 rtl/binary_to_bcd.sv | 135 +++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared display-path definitions.
// Holds the BCD digit width, the binary-to-BCD FSM state encoding and the
// saturation digit used when a value does not fit in the display.
package display_pkg;

    localparam int BCD_DIGIT_W = 4;

    localparam logic [BCD_DIGIT_W-1:0] BCD_NINE = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } bcd_state_e;

endpackage : display_pkg

// File: rtl/bcd_digit_adjust.sv
// Single-digit correction for the shift-and-add-3 algorithm.
// Ports:
//   digit_i : current 4-bit working digit
//   digit_o : digit_i + 3 when digit_i >= 5, otherwise digit_i unchanged
// A corrected digit of 5..9 becomes 8..12, so the following left shift
// pushes a carry into the next digit exactly when the doubled value
// reaches ten.
module bcd_digit_adjust
    import display_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    // Conditional add-3 correction
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end else begin
            digit_o = digit_i;
        end
    end

endmodule : bcd_digit_adjust

// File: rtl/binary_to_bcd.sv
// Sequential binary-to-BCD converter, one input bit per clock.
// Ports:
//   clk      : system clock, rising edge
//   reset    : synchronous active-high reset
//   start    : conversion request, honoured only while idle
//   bin      : unsigned binary value, captured on the accepted start cycle
//   busy     : high from the cycle after an accepted start through done
//   done     : one-cycle pulse; bcd/overflow update on this same cycle
//   bcd      : packed BCD digits, digit 0 (ones) in the LSBs
//   overflow : last converted value did not fit in DIGITS digits
// Values that overflow are shown as all nines. All outputs are registered.
module binary_to_bcd
    import display_pkg::*;
#(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [BIN_WIDTH-1:0]          bin,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          overflow
);

    localparam int WORK_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W  = $clog2(BIN_WIDTH + 1);

    localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(BIN_WIDTH);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [WORK_W-1:0]    WORK_ZERO = {WORK_W{1'b0}};
    localparam logic [WORK_W-1:0]    WORK_SAT  = {DIGITS{BCD_NINE}};
    localparam logic [BIN_WIDTH-1:0] SHIFT_ZERO = {BIN_WIDTH{1'b0}};

    bcd_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIN_WIDTH-1:0]   shift_q, shift_d;
    logic [WORK_W-1:0]      work_q, work_d;
    logic                   ovf_q, ovf_d;
    logic [WORK_W-1:0]      bcd_q, bcd_d;
    logic                   overflow_q, overflow_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic [WORK_W-1:0]      adj_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (work_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (adj_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Next-state, datapath and output-register logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        work_d     = work_q;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        busy_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d = bin;
                    work_d  = WORK_ZERO;
                    ovf_d   = 1'b0;
                    cnt_d   = CNT_LOAD;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                busy_d = 1'b1;
                // {carry, digits, shift} << 1: the top corrected bit is the
                // carry out of the last digit and is dropped into the flag.
                {work_d, shift_d} = {adj_s[WORK_W-2:0], shift_q, 1'b0};
                ovf_d = ovf_q | adj_s[WORK_W-1];
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                busy_d     = 1'b1;
                done_d     = 1'b1;
                overflow_d = ovf_q;
                bcd_d      = ovf_q ? WORK_SAT : work_q;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, working and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            shift_q    <= SHIFT_ZERO;
            work_q     <= WORK_ZERO;
            ovf_q      <= 1'b0;
            bcd_q      <= WORK_ZERO;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            work_q     <= work_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = overflow_q;

endmodule : binary_to_bcd
